// File: rtl/sparse_conv_core.sv
// Sparse 4b x 4b conv core: CH channels of K-tap dot products, single-beat or accumulated groups.
// Latency 3 cycles accept-to-o_valid; o_valid && !o_ready freezes every stage and drops i_ready.
module sparse_conv_core #(
    parameter int CH    = 8,
    parameter int K     = 8,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [CH*K*4-1:0]     i_Weight,
    input  logic [CH*K*4-1:0]     i_Activation,
    input  logic                  i_acc,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [CH*ACC_W-1:0]   o_result,
    output logic [CH-1:0]         o_sat,
    output logic [31:0]           o_skip_cnt
);
    localparam int N     = CH * K;
    localparam int SUM_W = 8 + $clog2(K);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic adv;
    logic accept;
    logic o_valid_q, o_valid_d;

    assign adv     = !(o_valid_q && !o_ready);
    assign i_ready = adv;
    assign accept  = i_valid && adv;

    // Stage 1: products and zero-weight accounting
    logic [N-1:0][7:0] prod_q, prod_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_acc_q, s1_acc_d;
    logic              s1_last_q, s1_last_d;
    logic [31:0]       skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0]  zero_cnt;
    logic [3:0]        w_t;
    logic [3:0]        a_t;
    logic [7:0]        prod_t;
    logic [32:0]       skip_sum;

    always_comb begin
        prod_d    = prod_q;
        s1_acc_d  = s1_acc_q;
        s1_last_d = s1_last_q;
        s1_vld_d  = adv ? accept : s1_vld_q;
        zero_cnt  = '0;
        w_t       = '0;
        a_t       = '0;
        prod_t    = '0;
        for (int t = 0; t < N; t++) begin
            w_t = i_Weight[t*4 +: 4];
            // a zero weight forces the activation operand to zero so the multiplier sees constant inputs
            a_t = (w_t == 4'd0) ? 4'd0 : i_Activation[t*4 +: 4];
            prod_t = {{4{w_t[3]}}, w_t} * {4'd0, a_t};
            if (w_t == 4'd0) begin
                zero_cnt = zero_cnt + CNT_W'(1);
            end
            if (accept) begin
                prod_d[t] = prod_t;
            end
        end
        if (accept) begin
            s1_acc_d  = i_acc;
            s1_last_d = i_last;
        end
        skip_sum   = {1'b0, skip_cnt_q} + {{(33-CNT_W){1'b0}}, zero_cnt};
        skip_cnt_d = skip_cnt_q;
        if (accept) begin
            skip_cnt_d = skip_sum[32] ? '1 : skip_sum[31:0];
        end
    end

    // Stage 2: per-channel sum at full precision
    logic [CH-1:0][SUM_W-1:0] sum_q, sum_d;
    logic                     s2_vld_q, s2_vld_d;
    logic                     s2_acc_q, s2_acc_d;
    logic                     s2_last_q, s2_last_d;
    logic [SUM_W-1:0]         tree;

    always_comb begin
        sum_d     = sum_q;
        s2_acc_d  = s2_acc_q;
        s2_last_d = s2_last_q;
        s2_vld_d  = adv ? s1_vld_q : s2_vld_q;
        tree      = '0;
        for (int c = 0; c < CH; c++) begin
            tree = '0;
            for (int k = 0; k < K; k++) begin
                tree = tree + {{(SUM_W-8){prod_q[c*K+k][7]}}, prod_q[c*K+k]};
            end
            if (adv && s1_vld_q) begin
                sum_d[c] = tree;
            end
        end
        if (adv && s1_vld_q) begin
            s2_acc_d  = s1_acc_q;
            s2_last_d = s1_last_q;
        end
    end

    // Stage 3: accumulate with saturation; a single-beat op never reuses the open partial sum
    logic [CH-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [CH-1:0]            sat_q, sat_d;
    logic                     open_q, open_d;
    logic                     s3_load;
    logic                     beat_final;
    logic                     keep;
    logic [ACC_W:0]           sum_x;
    logic [ACC_W:0]           base_x;
    logic [ACC_W:0]           tot;

    always_comb begin
        acc_d      = acc_q;
        sat_d      = sat_q;
        open_d     = open_q;
        sum_x      = '0;
        base_x     = '0;
        tot        = '0;
        s3_load    = adv && s2_vld_q;
        beat_final = !s2_acc_q || s2_last_q;
        keep       = s2_acc_q && open_q;
        o_valid_d  = s3_load ? beat_final : (o_valid_q && !o_ready);
        if (s3_load) begin
            open_d = s2_acc_q && !s2_last_q;
            for (int c = 0; c < CH; c++) begin
                sum_x  = {{(ACC_W+1-SUM_W){sum_q[c][SUM_W-1]}}, sum_q[c]};
                base_x = keep ? {acc_q[c][ACC_W-1], acc_q[c]} : '0;
                tot    = base_x + sum_x;
                if (tot[ACC_W] != tot[ACC_W-1]) begin
                    acc_d[c] = tot[ACC_W] ? ACC_MIN : ACC_MAX;
                    sat_d[c] = 1'b1;
                end else begin
                    acc_d[c] = tot[ACC_W-1:0];
                    sat_d[c] = keep && sat_q[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_acc_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            skip_cnt_q <= '0;
            sum_q      <= '0;
            s2_vld_q   <= 1'b0;
            s2_acc_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            sat_q      <= '0;
            open_q     <= 1'b0;
            o_valid_q  <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            s1_vld_q   <= s1_vld_d;
            s1_acc_q   <= s1_acc_d;
            s1_last_q  <= s1_last_d;
            skip_cnt_q <= skip_cnt_d;
            sum_q      <= sum_d;
            s2_vld_q   <= s2_vld_d;
            s2_acc_q   <= s2_acc_d;
            s2_last_q  <= s2_last_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            open_q     <= open_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_result   = acc_q;
    assign o_sat      = sat_q;
    assign o_skip_cnt = skip_cnt_q;

endmodule
